// File: rtl/fft_frame_streamer_if.sv
// Stream bundle between the sample source, the frame streamer and the FFT sink port.
interface fft_frame_streamer_if #(
  parameter int DATA_W = 14,
  parameter int PTS_W  = 11
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
  logic [DATA_W-1:0] src_real;
  logic [DATA_W-1:0] src_imag;
  logic [1:0]        src_error;
  logic [PTS_W-1:0]  src_fftpts;
  logic              src_inverse;

  // Streamer side: consumes input samples, drives the FFT sink.
  modport master (
    input  in_valid, in_real, in_imag, src_ready,
    output in_ready, src_valid, src_sop, src_eop, src_real, src_imag,
           src_error, src_fftpts, src_inverse
  );

  // Environment side: sample producer and FFT sink.
  modport slave (
    output in_valid, in_real, in_imag, src_ready,
    input  in_ready, src_valid, src_sop, src_eop, src_real, src_imag,
           src_error, src_fftpts, src_inverse
  );
endinterface

// File: rtl/fft_frame_streamer.sv
// Buffers complex samples and releases them to the FFT sink as complete,
// gap-free frames with frame-latched point count and direction.
module fft_frame_streamer #(
  parameter int DATA_W = 14,
  parameter int PTS_W  = 11,
  parameter int DEPTH  = 2048
) (
  input  logic                    clk,
  input  logic                    reset_n,
  fft_frame_streamer_if.master    st,
  input  logic                    enable,
  input  logic [PTS_W-1:0]        cfg_fftpts,
  input  logic                    cfg_inverse,
  input  logic                    sts_clr,
  output logic                    sts_cfg_err,
  output logic [PTS_W:0]          sts_level
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [PTS_W:0]   DEPTH_L = (PTS_W+1)'(DEPTH);
  localparam logic [PTS_W-1:0] MIN_PTS = PTS_W'(8);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state, state_nxt;
  logic [PTS_W-1:0]    beat, beat_nxt, n_pts;
  logic [PTS_W:0]      level;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic                rdy_en, in_acc, out_acc, cfg_legal;
  logic                start, load, err_set;
  logic [DATA_W-1:0]   out_real, out_imag;
  logic [PTS_W-1:0]    out_fftpts;
  logic                out_inverse;

  assign st.in_ready    = rdy_en && (level < DEPTH_L);
  assign in_acc         = st.in_valid && st.in_ready;
  assign out_acc        = st.src_valid && st.src_ready;
  assign st.src_valid   = (state == STREAM);
  assign st.src_sop     = (state == STREAM) && (beat == '0);
  assign st.src_eop     = (state == STREAM) && (beat == n_pts - PTS_W'(1));
  assign st.src_real    = out_real;
  assign st.src_imag    = out_imag;
  assign st.src_error   = '0;
  assign st.src_fftpts  = out_fftpts;
  assign st.src_inverse = out_inverse;
  assign sts_level      = level;
  assign cfg_legal      = $onehot(cfg_fftpts) && (cfg_fftpts >= MIN_PTS);

  // Frame sequencing: start only once a whole frame is buffered, then beat count to eop.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    start     = 1'b0;
    load      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          if (!cfg_legal) begin
            err_set = 1'b1;
          end else if (level >= {1'b0, cfg_fftpts}) begin
            start     = 1'b1;
            load      = 1'b1;
            beat_nxt  = '0;
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        if (out_acc) begin
          if (st.src_eop) begin
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + PTS_W'(1);
            load     = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Input ready is withheld while in reset and released on the first clock after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // Sample storage; no reset needed since pointers/level define validity.
  always_ff @(posedge clk) begin
    if (in_acc) mem[wr_ptr] <= {st.in_real, st.in_imag};
  end

  // Pointers, occupancy and output register. The output register counts toward level
  // until its beat is accepted, so it is not a separate "empty" state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      n_pts       <= '0;
      out_real    <= '0;
      out_imag    <= '0;
      out_fftpts  <= '0;
      out_inverse <= 1'b0;
    end else begin
      level <= level + (PTS_W+1)'(in_acc) - (PTS_W+1)'(out_acc);
      if (in_acc) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        {out_real, out_imag} <= mem[rd_ptr];
        rd_ptr               <= rd_ptr + AW'(1);
      end
      if (start) begin
        n_pts       <= cfg_fftpts;
        out_fftpts  <= cfg_fftpts;
        out_inverse <= cfg_inverse;
      end
    end
  end

  // Sticky illegal-configuration flag; a set in the same cycle as clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     sts_cfg_err <= 1'b0;
    else if (err_set) sts_cfg_err <= 1'b1;
    else if (sts_clr) sts_cfg_err <= 1'b0;
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench for fft_frame_streamer: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares on every accepted output beat.
module tb_fft_frame_streamer;

  typedef struct packed {
    logic        vld;
    logic [13:0] re;
    logic [13:0] im;
    logic        sop;
    logic        eop;
    logic [10:0] pts;
    logic        inv;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] cfg_fftpts = '0;
  logic        cfg_inverse = 1'b0;
  logic        sts_clr = 1'b0;
  logic        sts_cfg_err;
  logic [11:0] sts_level;

  logic        stall_mode = 1'b0;
  logic        ready_force = 1'b1;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  beat_t       exp_q[$];

  fft_frame_streamer_if #(.DATA_W(14), .PTS_W(11)) st ();

  fft_frame_streamer #(.DATA_W(14), .PTS_W(11), .DEPTH(2048)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .st          (st),
    .enable      (enable),
    .cfg_fftpts  (cfg_fftpts),
    .cfg_inverse (cfg_inverse),
    .sts_clr     (sts_clr),
    .sts_cfg_err (sts_cfg_err),
    .sts_level   (sts_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  function automatic logic [13:0] dre(input int v);
    return 14'(v);
  endfunction

  function automatic logic [13:0] dim(input int v);
    return ~14'(v);
  endfunction

  // Expected beats for nfr consecutive frames of n samples, data index from start.
  task automatic expect_frames(input int nfr, input int n, input int start, input logic inv);
    beat_t b;
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < n; k++) begin
        b.vld = 1'b1;
        b.re  = dre(start + f * n + k);
        b.im  = dim(start + f * n + k);
        b.sop = (k == 0);
        b.eop = (k == n - 1);
        b.pts = 11'(n);
        b.inv = inv;
        exp_q.push_back(b);
      end
    end
  endtask

  // One input sample; returns at posedge+1 right after acceptance.
  task automatic push(input logic [13:0] r, input logic [13:0] im);
    int unsigned n;
    n = 0;
    st.in_valid = 1'b1;
    st.in_real  = r;
    st.in_imag  = im;
    @(negedge clk);
    while (!st.in_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) chk("push_timeout", 64'(1), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int count, input int start);
    for (int k = 0; k < count; k++) push(dre(start + k), dim(start + k));
    st.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int unsigned bound);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      n++;
      @(negedge clk);
    end
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  // Sink ready: random under stall_mode, otherwise the forced level.
  always @(posedge clk) begin
    #1;
    st.src_ready = stall_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: scoreboard pop on accepted beats, hold stability, in-frame and post-eop gaps.
  beat_t cur, prev, e;
  logic  stalled = 1'b0, eop_done = 1'b0, in_frame = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled  = 1'b0;
      eop_done = 1'b0;
      in_frame = 1'b0;
    end else begin
      cur = {st.src_valid, st.src_real, st.src_imag, st.src_sop, st.src_eop,
             st.src_fftpts, st.src_inverse};
      if (eop_done) chk("gap_after_eop", 64'(st.src_valid), 64'(0));
      eop_done = 1'b0;
      if (stalled) chk("stall_hold", 64'(cur), 64'(prev));
      if (in_frame) chk("no_gap_in_frame", 64'(st.src_valid), 64'(1));
      chk("src_error", 64'(st.src_error), 64'(0));
      if (st.src_valid && st.src_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(cur), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'(cur), 64'(e));
        end
        in_frame = !st.src_eop;
        eop_done = st.src_eop;
      end
      stalled = st.src_valid && !st.src_ready;
      prev    = cur;
    end
  end

  initial begin
    st.in_valid  = 1'b0;
    st.in_real   = '0;
    st.in_imag   = '0;
    st.src_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_in_ready", 64'(st.in_ready), 64'(0));
    chk("rst_src_valid", 64'(st.src_valid), 64'(0));
    chk("rst_level", 64'(sts_level), 64'(0));
    chk("rst_err", 64'(sts_cfg_err), 64'(0));
    chk("rst_fftpts", 64'(st.src_fftpts), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(st.in_ready), 64'(1));

    // 1: one 64-point frame of ramp 0..63.
    cfg_fftpts = 11'd64; cfg_inverse = 1'b0; enable = 1'b1;
    expect_frames(1, 64, 0, 1'b0);
    @(posedge clk); #1;
    feed(64, 0);
    wait_drain("t1_drain", 200);

    // 2: 63 samples hold back the frame, the 64th releases it.
    expect_frames(1, 64, 100, 1'b0);
    @(posedge clk); #1;
    feed(63, 100);
    repeat (10) @(negedge clk);
    chk("t2_level63", 64'(sts_level), 64'(63));
    chk("t2_no_valid", 64'(st.src_valid), 64'(0));
    @(posedge clk); #1;
    feed(1, 163);
    wait_drain("t2_drain", 200);
    @(negedge clk);
    chk("t2_level0", 64'(sts_level), 64'(0));

    // 3: four 1024-point frames under random backpressure.
    cfg_fftpts = 11'd1024;
    stall_mode = 1'b1;
    expect_frames(4, 1024, 2000, 1'b0);
    @(posedge clk); #1;
    feed(4096, 2000);
    wait_drain("t3_drain", 20000);
    stall_mode = 1'b0;

    // 4: config change mid-frame applies only to the next frame.
    cfg_fftpts = 11'd256; cfg_inverse = 1'b0;
    expect_frames(1, 256, 9000, 1'b0);
    expect_frames(1, 128, 9256, 1'b1);
    @(posedge clk); #1;
    feed(256, 9000);
    repeat (3) @(posedge clk);
    #1;
    cfg_fftpts = 11'd128; cfg_inverse = 1'b1;
    feed(128, 9256);
    wait_drain("t4_drain", 2000);
    chk("t4_err_clear", 64'(sts_cfg_err), 64'(0));

    // 5: illegal length blocks output and sets sticky error; then drain as 8-point frames.
    cfg_fftpts = 11'd100; cfg_inverse = 1'b0;
    @(posedge clk); #1;
    feed(200, 7000);
    repeat (5) @(negedge clk);
    chk("t5_no_valid", 64'(st.src_valid), 64'(0));
    chk("t5_level", 64'(sts_level), 64'(200));
    chk("t5_err_set", 64'(sts_cfg_err), 64'(1));
    enable = 1'b0;
    @(posedge clk); #1;
    sts_clr = 1'b1;
    @(posedge clk); #1;
    sts_clr = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", 64'(sts_cfg_err), 64'(0));
    cfg_fftpts = 11'd8;
    expect_frames(25, 8, 7000, 1'b0);
    enable = 1'b1;
    wait_drain("t5_drain", 1000);

    // 6: fill to depth with sink stalled, dropped writes, then reset mid-frame.
    ready_force = 1'b0;
    cfg_fftpts = 11'd1024;
    @(posedge clk); #1;
    feed(2048, 0);
    @(negedge clk);
    chk("t6_level_full", 64'(sts_level), 64'(2048));
    chk("t6_in_ready0", 64'(st.in_ready), 64'(0));
    chk("t6_stalled_valid", 64'(st.src_valid), 64'(1));
    @(posedge clk); #1;
    st.in_valid = 1'b1;
    st.in_real  = 14'h1555;
    repeat (4) @(posedge clk);
    #1;
    st.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_level_hold", 64'(sts_level), 64'(2048));
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(st.src_valid), 64'(0));
    chk("t6_rst_level", 64'(sts_level), 64'(0));
    chk("t6_rst_in_ready", 64'(st.in_ready), 64'(0));
    chk("t6_rst_fftpts", 64'(st.src_fftpts), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_post_in_ready", 64'(st.in_ready), 64'(1));
    chk("t6_post_valid", 64'(st.src_valid), 64'(0));
    chk("t6_post_level", 64'(sts_level), 64'(0));

    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
